// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with zero/ones/parity flags.
// A registered output stage plus one skid entry gives full throughput under backpressure.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             ZERO,
  output logic             ONES,
  output logic             PARITY
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             parity;
  } res_t;

  logic [1:0] state_q, state_d;
  res_t       or_q, or_d, sk_q, sk_d;
  res_t       res_new;
  logic [WIDTH-1:0] y_new;
  logic       accept, emit;

  always_comb begin
    y_new = '0;
    case (OP)
      3'b000: y_new = A & B;
      3'b001: y_new = ~(A & B);
      3'b010: y_new = ~(A ^ B);
      3'b011: y_new = A | B;
      3'b100: y_new = ~(A | B);
      3'b101: y_new = A ^ B;
      3'b110: y_new = A;
      3'b111: y_new = ~A;
    endcase
    // Flags travel with the result so they stay consistent while held.
    res_new.y      = y_new;
    res_new.zero   = ~|y_new;
    res_new.ones   = &y_new;
    res_new.parity = ^y_new;
  end

  assign in_ready  = (state_q != FULL) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sk_d    = sk_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          or_d    = res_new;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          or_d = res_new;
        end else if (accept) begin
          sk_d    = res_new;
          state_d = FULL;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          or_d    = sk_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      or_q    <= '0;
      sk_q    <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sk_q    <= sk_d;
    end
  end

  assign Y      = or_q.y;
  assign ZERO   = or_q.zero;
  assign ONES   = or_q.ones;
  assign PARITY = or_q.parity;

endmodule
